// File: rtl/aud_pkg.sv
// Shared types and constants for the audio playback path.
package aud_pkg;

  localparam int unsigned AUD_DATA_W = 16;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LEFT, S_RIGHT} play_state_t;

endpackage

// File: rtl/aud_i2s_serializer.sv
// MSB-first shift register for one I2S channel slot; output is 0 once all bits are out.
module aud_i2s_serializer
  import aud_pkg::*;
#(
  parameter int unsigned DATA_W = AUD_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic              o_dacdat
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;

  always_comb begin
    sh_d     = sh_q;
    bitcnt_d = bitcnt_q;
    // A load always wins, even mid-shift on a short LRC period.
    if (load) begin
      sh_d     = load_data;
      bitcnt_d = CNT_W'(DATA_W);
    end else if (bitcnt_q != '0) begin
      sh_d     = sh_q << 1;
      bitcnt_d = bitcnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sh_q     <= '0;
      bitcnt_q <= '0;
    end else begin
      sh_q     <= sh_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  assign o_dacdat = (bitcnt_q != '0) & sh_q[DATA_W-1];

endmodule

// File: rtl/aud_player.sv
// Playback-side I2S serializer for the WM8731 DAC: skid buffer, frame FSM,
// underrun counting and stop handling, all in the BCLK domain.
module aud_player
  import aud_pkg::*;
#(
  parameter int unsigned DATA_W = AUD_DATA_W,
  parameter int unsigned UNDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_lrc,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_aud_dacdat,
  output logic [UNDR_W-1:0] o_underrun,
  output logic              o_finish
);

  play_state_t       state_q, state_d;
  logic              lrc_q;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              buf_full_q, buf_full_d;
  logic [DATA_W-1:0] cur_q, cur_d;
  logic [UNDR_W-1:0] undr_q, undr_d;
  logic              stop_pend_q, stop_pend_d;
  logic              finish_q, finish_d;

  logic              rise, fall, ready, frame_load, load, ser_dat;
  logic [DATA_W-1:0] load_data;

  assign rise  = i_lrc & ~lrc_q;
  assign fall  = ~i_lrc & lrc_q;
  assign ready = ~buf_full_q & (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    buf_data_d  = buf_data_q;
    buf_full_d  = buf_full_q;
    cur_d       = cur_q;
    undr_d      = undr_q;
    stop_pend_d = stop_pend_q;
    frame_load  = 1'b0;
    load        = 1'b0;
    load_data   = cur_q;

    unique case (state_q)
      S_IDLE: begin
        buf_full_d  = 1'b0;
        stop_pend_d = 1'b0;
        if (i_start) begin
          state_d = S_WAIT;
          undr_d  = '0;
        end
      end
      S_WAIT: begin
        if (i_stop) begin
          stop_pend_d = 1'b1;
          state_d     = S_IDLE;
        end else if (rise) begin
          frame_load = 1'b1;
          state_d    = S_LEFT;
        end
      end
      S_LEFT: begin
        if (i_stop) stop_pend_d = 1'b1;
        if (fall) begin
          load    = 1'b1;
          state_d = S_RIGHT;
        end
      end
      S_RIGHT: begin
        if (i_stop) stop_pend_d = 1'b1;
        if (rise) begin
          if (stop_pend_q | i_stop) begin
            state_d = S_IDLE;
          end else begin
            frame_load = 1'b1;
            state_d    = S_LEFT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_load) begin
      load = 1'b1;
      if (i_pause) begin
        cur_d = '0;
      end else if (buf_full_q) begin
        cur_d      = buf_data_q;
        buf_full_d = 1'b0;
      end else begin
        cur_d = '0;
        if (undr_q != '1) undr_d = undr_q + UNDR_W'(1);
      end
      load_data = cur_d;
    end

    // A load that empties the buffer never coincides with an accept: ready was low.
    if (i_valid & ready) begin
      buf_data_d = i_data;
      buf_full_d = 1'b1;
    end
  end

  assign finish_d = (state_q != S_IDLE) && (state_d == S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      lrc_q       <= 1'b0;
      buf_data_q  <= '0;
      buf_full_q  <= 1'b0;
      cur_q       <= '0;
      undr_q      <= '0;
      stop_pend_q <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lrc_q       <= i_lrc;
      buf_data_q  <= buf_data_d;
      buf_full_q  <= buf_full_d;
      cur_q       <= cur_d;
      undr_q      <= undr_d;
      stop_pend_q <= stop_pend_d;
      finish_q    <= finish_d;
    end
  end

  aud_i2s_serializer #(.DATA_W(DATA_W)) u_ser (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .load      (load),
    .load_data (load_data),
    .o_dacdat  (ser_dat)
  );

  // Idle forces silence even if a short final slot left bits in the shifter.
  assign o_aud_dacdat = ser_dat & (state_q != S_IDLE);
  assign o_ready      = ready;
  assign o_underrun   = undr_q;
  assign o_finish     = finish_q;

endmodule

// File: tb/tb_aud_player.sv
// Table-driven frame bench with an expected-word scoreboard for aud_player.
module tb_aud_player;

  localparam int HALF = 20;

  logic        clk = 1'b0;
  logic        rst, lrc, start, pause, stop, valid;
  logic [15:0] data;
  logic        ready, dac, finish;
  logic [15:0] undr;
  logic        ready4, dac4, fin4;
  logic [3:0]  undr4;

  int          n_vec = 0;
  int          n_err = 0;
  int          fin_cnt = 0;
  logic [15:0] sb_q[$];
  int          undr_m;
  logic        held_m;
  logic [15:0] held_d;
  logic        mon_busy = 1'b0;

  typedef struct {
    logic        st;
    logic        v;
    logic [15:0] d;
    logic        p;
  } vec_t;
  vec_t tbl[11];

  aud_player dut (
    .i_clk(clk), .i_rst(rst), .i_lrc(lrc), .i_start(start), .i_pause(pause),
    .i_stop(stop), .i_valid(valid), .i_data(data), .o_ready(ready),
    .o_aud_dacdat(dac), .o_underrun(undr), .o_finish(finish)
  );

  aud_player #(.UNDR_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_lrc(lrc), .i_start(start), .i_pause(pause),
    .i_stop(stop), .i_valid(valid), .i_data(data), .o_ready(ready4),
    .o_aud_dacdat(dac4), .o_underrun(undr4), .o_finish(fin4)
  );

  always #5 clk = ~clk;

  initial begin : lrc_gen
    lrc = 1'b0;
    forever begin
      repeat (HALF) @(negedge clk);
      lrc = ~lrc;
    end
  end

  always @(negedge clk) fin_cnt <= fin_cnt + int'(finish);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic grab(output logic [15:0] w, output logic [15:0] w4);
    w = '0;
    w4 = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      w  = {w[14:0], dac};
      w4 = {w4[14:0], dac4};
    end
    @(negedge clk);
    chk("trail_zero", dac, 0);
  endtask

  initial begin : mon
    logic        prev;
    logic [15:0] exp, w, w4;
    int          t;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      if (lrc && !prev && sb_q.size() != 0) begin
        mon_busy = 1'b1;
        exp = sb_q.pop_front();
        grab(w, w4);
        chk("left_word", w, exp);
        chk("left_word4", w4, exp);
        t = 0;
        while (lrc && t < 100) begin
          @(posedge clk);
          t++;
        end
        chk("fall_seen", lrc, 0);
        grab(w, w4);
        chk("right_word", w, exp);
        chk("right_word4", w4, exp);
        mon_busy = 1'b0;
      end
      prev = lrc;
    end
  end

  task automatic send(input logic [15:0] d);
    int t;
    valid = 1'b1;
    data  = d;
    t = 0;
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept", ready, 1);
    @(negedge clk);
    valid = 1'b0;
    held_m = 1'b1;
    held_d = d;
  endtask

  // One frame: drive in mid right slot, predict the word loaded at the next rise.
  task automatic frame(input logic st, input logic v, input logic [15:0] d, input logic p);
    logic [15:0] exp;
    @(negedge lrc);
    repeat (3) @(negedge clk);
    if (st) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      undr_m = 0;
      held_m = 1'b0;
    end
    pause = p;
    chk("ready", ready, {31'd0, !held_m});
    chk("ready4", ready4, {31'd0, !held_m});
    if (v) send(d);
    if (p) exp = '0;
    else if (held_m) begin
      exp = held_d;
      held_m = 1'b0;
    end else begin
      exp = '0;
      undr_m++;
    end
    sb_q.push_back(exp);
    @(posedge lrc);
    repeat (2) @(negedge clk);
    chk("underrun", undr, undr_m);
    chk("underrun4", undr4, (undr_m > 15) ? 15 : undr_m);
  endtask

  // Stop pulsed mid-left; finish must follow the next rise by one cycle.
  task automatic do_stop();
    int base;
    repeat (3) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    base = fin_cnt;
    @(posedge lrc);
    chk("no_early_finish", fin_cnt, base);
    chk("finish_before", finish, 0);
    @(negedge clk);
    chk("finish_pulse", finish, 1);
    chk("finish_pulse4", fin4, 1);
    chk("ready_idle", ready, 0);
    chk("dac_idle", dac, 0);
    @(negedge clk);
    chk("finish_clear", finish, 0);
    repeat (20) @(negedge clk);
    chk("finish_once", fin_cnt, base + 1);
    chk("dac_idle_later", dac, 0);
  endtask

  initial begin : main
    int t;
    tbl[0]  = '{st: 1'b1, v: 1'b1, d: 16'hA5C3, p: 1'b0};
    tbl[1]  = '{st: 1'b0, v: 1'b0, d: 16'h0000, p: 1'b0};
    tbl[2]  = '{st: 1'b0, v: 1'b0, d: 16'h0000, p: 1'b0};
    tbl[3]  = '{st: 1'b0, v: 1'b0, d: 16'h0000, p: 1'b0};
    tbl[4]  = '{st: 1'b0, v: 1'b1, d: 16'h1234, p: 1'b0};
    tbl[5]  = '{st: 1'b0, v: 1'b1, d: 16'h7FFF, p: 1'b1};
    tbl[6]  = '{st: 1'b0, v: 1'b0, d: 16'h0000, p: 1'b1};
    tbl[7]  = '{st: 1'b0, v: 1'b0, d: 16'h0000, p: 1'b0};
    tbl[8]  = '{st: 1'b0, v: 1'b1, d: 16'h8001, p: 1'b0};
    tbl[9]  = '{st: 1'b0, v: 1'b1, d: 16'hFFFF, p: 1'b0};
    tbl[10] = '{st: 1'b0, v: 1'b1, d: 16'h0001, p: 1'b0};

    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; valid = 1'b0; data = '0;
    undr_m = 0; held_m = 1'b0; held_d = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {dac, ready, finish, undr}, 0);
    rst = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      chk("idle_outs", {dac, ready, finish, undr}, 0);
      chk("idle_outs4", {dac4, ready4, fin4, undr4}, 0);
    end

    for (int i = 0; i < 11; i++) frame(tbl[i].st, tbl[i].v, tbl[i].d, tbl[i].p);
    do_stop();

    frame(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 19; i++) frame(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("underrun_sat4", undr4, 4'hF);
    do_stop();

    @(negedge lrc);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("wait_ready", ready, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("wait_stop_finish", finish, 1);
    chk("wait_stop_ready", ready, 0);
    @(negedge clk);
    chk("wait_stop_clear", finish, 0);

    t = 0;
    while ((sb_q.size() != 0 || mon_busy) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aud_player.md
# aud_player

Playback-side I2S serializer for the WM8731 DAC path, mirroring the recorder on the capture side. It accepts 16-bit mono samples from the SRAM-read/DSP stage over a valid/ready handshake, holds one sample in a skid register, and shifts each sample out MSB-first on `o_aud_dacdat` in both left and right channel slots. It runs entirely in the codec bit-clock domain and reports underruns and end of playback.

## Interface
- `DATA_W`, 16, sample width (bits shifted per channel slot).
- `UNDR_W`, 16, underrun counter width.

- `i_clk`  in  1  codec BCLK; all logic on posedge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_lrc`  in  1  codec DACLRC; 1 = left slot, 0 = right slot.
- `i_start`  in  1  one-cycle pulse; begin playback.
- `i_pause`  in  1  level; while high, frames play silence and no sample is consumed.
- `i_stop`  in  1  one-cycle pulse; end playback at the next frame boundary.
- `i_valid`  in  1  upstream sample valid.
- `i_data`  in  DATA_W  upstream sample, two's complement.
- `o_ready`  out  1  skid register empty and block not idle.
- `o_aud_dacdat`  out  1  serial DAC data.
- `o_underrun`  out  UNDR_W  frames played as silence for lack of data (saturating).
- `o_finish`  out  1  one-cycle pulse on return to idle.

## Operation
- `lrc_d` registers `i_lrc` every cycle.
  - Rise = `i_lrc & ~lrc_d`.
  - Fall = `~i_lrc & lrc_d`.
- Skid register `buf`/`buf_full`:
  - Accepts on `i_valid & o_ready`.
  - `o_ready = buf_full==0 && state!=S_IDLE`.
- States:
  - **S_IDLE**
    - Outputs 0; `buf_full` cleared.
    - On `i_start`: go to S_WAIT and clear `o_underrun`.
  - **S_WAIT**
    - Waits for Rise, then performs a frame load and goes to S_LEFT.
  - **Frame load (at Rise)**
    - `i_pause=1`: `cur=0`; `buf` untouched.
    - Else if `buf_full`: `cur=buf` and `buf_full` cleared. An accept in the same cycle is not possible, because `o_ready` was 0.
    - Else: `cur=0` and `o_underrun` increments, saturating at all-ones.
    - `sh` (shift register) ← `cur`; `bitcnt` ← DATA_W.
  - **S_LEFT**
    - While `bitcnt>0`: shift `sh` left one bit per cycle and decrement `bitcnt`.
    - After that, `o_aud_dacdat=0`.
    - On Fall: `sh←cur`, `bitcnt←DATA_W`, go to S_RIGHT. The right channel duplicates the left.
  - **S_RIGHT**
    - Shifts the same way as S_LEFT.
    - On Rise:
      - If `stop_pend`: go to S_IDLE, pulse `o_finish`, drive `o_aud_dacdat=0`.
      - Else: frame load, go to S_LEFT.
- `o_aud_dacdat = sh[DATA_W-1]` whenever `bitcnt>0`, else 0.
- `i_stop` in any non-idle state sets `stop_pend`.
  - In S_WAIT it exits immediately: next cycle S_IDLE and `o_finish`.
  - Otherwise the current L+R frame completes.
  - `stop_pend` clears in S_IDLE.
- `i_start` outside S_IDLE is ignored. `i_stop` in S_IDLE is ignored.
- Edge detected mid-shift (short LRC): reload anyway; the truncated bits are lost.

## Timing
- Reset values: state S_IDLE, `lrc_d=0`, `buf_full=0`, `sh=0`, `bitcnt=0`, `cur=0`, `stop_pend=0`.
- Outputs after reset: `o_aud_dacdat=0`, `o_ready=0`, `o_underrun=0`, `o_finish=0`.
- Reset mid-frame aborts within one cycle. No `o_finish` is issued.
- Edge detect: registered compare, so Rise/Fall is recognised in the cycle `i_lrc` is first seen changed.
- Serial timing: MSB appears on `o_aud_dacdat` after the posedge at which the edge is detected. It is therefore stable at the codec's 2nd BCLK rise after the LRC change (I2S mode). Bit k (MSB=15) is driven during cycle 15-k after the load.
- Handshake: `o_ready` goes high the cycle after `buf` is emptied.
  - At most one sample is accepted per frame in steady state.
  - Upstream has a full frame (≥32 BCLK) to supply the next sample.
- `o_finish`: exactly one cycle, coincident with the transition into S_IDLE.

## Structure
- Shared package `aud_pkg`:
  - `typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LEFT, S_RIGHT} play_state_t`
  - `AUD_DATA_W = 16`
- Sub-module `aud_i2s_serializer` contains the load/shift/`bitcnt` logic and the `o_aud_dacdat` mux. Its inputs are `load`, `load_data`, `i_clk`, `i_rst`.
- All other logic is in `aud_player`: FSM, skid buffer, edge detect, underrun counter, stop logic.

## Test plan
- **Reset values:** reset held 3 cycles, then released with a free-running LRC → all outputs 0, `o_ready=0`, until `i_start`.
- **Basic playback:** `i_start`, `i_valid=1` with `i_data=16'hA5C3` before the first Rise → MSB-first 1010_0101_1100_0011 in the left slot and again in the right slot, zeros afterward; `o_underrun=0`.
- **Starvation:** `i_valid=0` for 3 frames → 3 silent frames; `o_underrun=3`; `o_ready` held 1.
- **Pause:** `i_pause` high across 2 frames with `buf` holding `16'h7FFF` → 2 silent frames, `buf` retained, `o_underrun` unchanged. `16'h7FFF` plays on the first frame after `i_pause` falls.
- **Stop:** `i_stop` in mid-left slot → the current frame finishes its right slot. At the next Rise: `o_finish` pulses once, state S_IDLE, `o_ready=0`.
- **Underrun saturation:** with `UNDR_W=4`, force 20 starved frames → `o_underrun=4'hF`.
